display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-slot scheduler for the 4-digit multiplexed seven-segment display. It fetches each digit's segment pattern from the timekeeping core through a request/acknowledge handshake. It blanks the bus between digits to suppress ghosting and gates the active window with a PWM brightness duty. It sits between the clock counters and the `uo_out`/`uio_out` pads and replaces free-running selector rotation.

## Interface
Reset is synchronous and active-high (`reset`, derived from `!rst_n` at top level). The block has a single clock, `clk`.

Parameters:
- `DIGITS`, 4: number of multiplexed digits.
- `SLOT_CYCLES`, 27000: clocks per digit slot (1 ms at 27 MHz).
- `BLANK_CYCLES`, 64: blanked clocks at the start of every slot.
- `BRIGHT_W`, 3: brightness width. Duty is in steps of 1/2^BRIGHT_W.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `enable`, in, 1: scan enable.
- `brightness`, in, BRIGHT_W: duty code.
- `digit_req`, out, 1: request pattern for `digit_idx`.
- `digit_idx`, out, clog2(DIGITS): digit being fetched or shown.
- `digit_ack`, in, 1: pattern valid this cycle.
- `digit_data`, in, 8: segments [6:0] plus dp [7].
- `selector`, out, DIGITS: one-hot digit enable, active-high.
- `segments`, out, 8: pattern to pads, active-high.
- `frame_tick`, out, 1: one-cycle pulse at the end of the last slot.
- `fetch_miss`, out, 1: one-cycle pulse when a fetch times out.

## Operation
- States are IDLE, FETCH, BLANK, ON and OFF. A slot counter runs 0..SLOT_CYCLES-1 in every non-IDLE state.
- IDLE → FETCH when `enable`=1. Slot count is 0, `digit_idx`=0, and `brightness` is latched.
- FETCH: `digit_req`=1 and `digit_idx` is held stable.
  - A cycle with `digit_req`&&`digit_ack` latches `digit_data`, drops `digit_req` the next cycle and moves to BLANK.
  - `digit_ack` is ignored while `digit_req`=0.
  - An ack in the same cycle the request rises counts.
- FETCH or BLANK → ON at slot count == BLANK_CYCLES.
  - If no ack has arrived by then: `fetch_miss` pulses, the latched pattern is cleared to 0 for this slot, and `digit_req` drops.
- ON: `selector` = one-hot(`digit_idx`) and `segments` = latched pattern.
  - The active window is SUB = (SLOT_CYCLES−BLANK_CYCLES)/2^BRIGHT_W clocks per step.
  - The digit stays lit for (`brightness`+1)·SUB clocks, then goes to OFF.
  - At the maximum code the digit is lit to slot end.
- OFF: `selector`=0 and `segments`=0 until slot end.
- Slot end (count == SLOT_CYCLES−1):
  - `digit_idx` wraps modulo DIGITS.
  - `brightness` is re-latched.
  - The next state is FETCH.
  - `frame_tick` pulses if `digit_idx` == DIGITS−1.
- In BLANK and FETCH, `selector`=0 and `segments`=0.
- `enable`=0 in any state → IDLE next cycle. All outputs go to 0 and `digit_idx` goes to 0. The current slot is not completed.
- A brightness change mid-slot takes effect at the next slot.

## Timing
- Reset values are all 0: `digit_req`, `digit_idx`, `selector`, `segments`, `frame_tick`, `fetch_miss`. State is IDLE.
- `reset` asserted mid-operation forces the same values on the next edge and overrides `enable`.
- `enable` rising at edge t puts `digit_req`=1 after edge t+1.
- `selector` asserts at slot count BLANK_CYCLES. The frame period is DIGITS·SLOT_CYCLES.
- All outputs are registered.

## Configuration
- `SCAN_BLINK_EN` defined:
  - Adds input `blink_mask` [DIGITS-1:0] and parameter `BLINK_FRAMES` (default 125).
  - A frame counter toggles an internal blink phase every BLINK_FRAMES `frame_tick`s. The phase resets to 0.
  - While phase=1, digits whose mask bit is set drive `segments`=0 in ON. `selector` timing is unchanged.
- `SCAN_BLINK_EN` undefined: no port, no counter, no phase.

## Structure
- Package `scan_pkg` holds:
  - the state enum,
  - the `BRIGHT_W` default,
  - a `clog2`-based index width helper.
- One sub-module, `scan_slot_timer`, contains the slot counter and provides BLANK-end, lit-end and slot-end strobes.

## Test plan
All scenarios use SLOT_CYCLES=40, BLANK_CYCLES=8, BRIGHT_W=3, SUB=4.
- `enable`=1, `digit_ack` tied 1, `digit_data`=8'h3F, `brightness`=7:
  - `selector`=0001 in slot cycles 8–39, then 0010 in the next slot.
  - `frame_tick` at the 160th cycle of the frame.
- `brightness`=1: lit in slot cycles 8–15, `selector`=0 in 16–39. Changing to 3 mid-slot takes effect the next slot (lit 8–23).
- `digit_ack` delayed 3 cycles: `digit_req` is high for exactly 3 cycles, `digit_idx` is stable, and `segments`=8'h3F in ON.
- `digit_ack` never asserted: `fetch_miss` pulses once at slot cycle 8, `segments`=0 for the whole slot, and `selector` still scans.
- `reset` at slot cycle 20 of digit 2: the next cycle has all outputs 0. After release with `enable`=1, the next fetch uses `digit_idx`=0.
- `SCAN_BLINK_EN`, BLINK_FRAMES=2, `blink_mask`=4'b0100: digit 2 `segments` are 0 in frames 2–3 and lit in frames 0–1 and 4–5, while the other digits stay lit.

Source files
------------

// File: rtl/scan_pkg.sv
// Shared types and helpers for the multiplexed display scan controller.
package scan_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BLANK,
    S_ON,
    S_OFF
  } scan_state_e;

  localparam int BRIGHT_W_DEF = 3;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot counter; produces the blank-end, lit-end and slot-end strobes
// from the current count so the controller can register its next outputs.
module scan_slot_timer
  import scan_pkg::*;
#(
  parameter int SLOT_CYCLES  = 27000,
  parameter int BLANK_CYCLES = 64,
  parameter int BRIGHT_W     = BRIGHT_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic [BRIGHT_W-1:0] bright,
  output logic                blank_end,
  output logic                lit_end,
  output logic                slot_end_pre,
  output logic                slot_end
);

  localparam int CW  = idx_w(SLOT_CYCLES);
  localparam int SUB = (SLOT_CYCLES - BLANK_CYCLES) >> BRIGHT_W;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   lit_last;

  assign blank_end    = (cnt_q == CW'(BLANK_CYCLES - 1));
  assign slot_end     = (cnt_q == CW'(SLOT_CYCLES - 1));
  assign slot_end_pre = (cnt_q == CW'(SLOT_CYCLES - 2));

  // The top brightness code never ends early: truncation of SUB must not
  // leave a dark tail at full brightness.
  assign lit_last = 32'(BLANK_CYCLES) + (32'(bright) + 32'd1) * 32'(SUB) - 32'd1;
  assign lit_end  = (bright != {BRIGHT_W{1'b1}}) && (32'(cnt_q) == lit_last);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (!run || slot_end) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan scheduler with fetch handshake, blanking and
// PWM brightness. Optional blink masking is built when SCAN_BLINK_EN is defined.
module display_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 27000,
  parameter int BLANK_CYCLES = 64,
  parameter int BRIGHT_W     = BRIGHT_W_DEF
`ifdef SCAN_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 125
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [BRIGHT_W-1:0]        brightness,
  output logic                       digit_req,
  output logic [idx_w(DIGITS)-1:0]   digit_idx,
  input  logic                       digit_ack,
  input  logic [7:0]                 digit_data,
`ifdef SCAN_BLINK_EN
  input  logic [DIGITS-1:0]          blink_mask,
`endif
  output logic [DIGITS-1:0]          selector,
  output logic [7:0]                 segments,
  output logic                       frame_tick,
  output logic                       fetch_miss
);

  localparam int IW = idx_w(DIGITS);

  scan_state_e         state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [7:0]          pat_q, pat_d;
  logic [BRIGHT_W-1:0] bright_q, bright_d;
  logic                digit_req_q, digit_req_d;
  logic [DIGITS-1:0]   selector_q, selector_d;
  logic [7:0]          segments_q, segments_d;
  logic                frame_tick_q, frame_tick_d;
  logic                fetch_miss_q, fetch_miss_d;
  logic                run, blank_end, lit_end, slot_end_pre, slot_end;
  logic                last_digit, got_ack, blink_off;

  assign run        = enable && (state_q != S_IDLE);
  assign last_digit = (idx_q == IW'(DIGITS - 1));
  assign got_ack    = digit_req_q && digit_ack;

  scan_slot_timer #(
    .SLOT_CYCLES (SLOT_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES),
    .BRIGHT_W    (BRIGHT_W)
  ) u_timer (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .bright      (bright_q),
    .blank_end   (blank_end),
    .lit_end     (lit_end),
    .slot_end_pre(slot_end_pre),
    .slot_end    (slot_end)
  );

`ifdef SCAN_BLINK_EN
  localparam int FW = idx_w(BLINK_FRAMES);
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (run && slot_end && last_digit) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign blink_off = phase_q && blink_mask[idx_d];
`else
  assign blink_off = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pat_d        = pat_q;
    bright_d     = bright_q;
    fetch_miss_d = 1'b0;
    frame_tick_d = 1'b0;
    if (!enable) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d  = S_FETCH;
          idx_d    = '0;
          bright_d = brightness;
        end
        S_FETCH: begin
          if (blank_end) begin
            state_d = S_ON;
            if (got_ack) begin
              pat_d = digit_data;
            end else begin
              pat_d        = '0;
              fetch_miss_d = 1'b1;
            end
          end else if (got_ack) begin
            pat_d   = digit_data;
            state_d = S_BLANK;
          end
        end
        S_BLANK: if (blank_end) state_d = S_ON;
        S_ON:    if (lit_end) state_d = S_OFF;
        S_OFF:   state_d = S_OFF;
        default: state_d = S_IDLE;
      endcase
      if (state_q != S_IDLE) begin
        frame_tick_d = slot_end_pre && last_digit;
        if (slot_end) begin
          state_d  = S_FETCH;
          idx_d    = last_digit ? '0 : idx_q + IW'(1);
          bright_d = brightness;
        end
      end
    end
  end

  // Outputs are registered from the next state so they line up with the count.
  always_comb begin
    digit_req_d = (state_d == S_FETCH);
    selector_d  = '0;
    segments_d  = '0;
    if (state_d == S_ON) begin
      selector_d[idx_d] = 1'b1;
      if (!blink_off) segments_d = pat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      pat_q        <= '0;
      bright_q     <= '0;
      digit_req_q  <= 1'b0;
      selector_q   <= '0;
      segments_q   <= '0;
      frame_tick_q <= 1'b0;
      fetch_miss_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pat_q        <= pat_d;
      bright_q     <= bright_d;
      digit_req_q  <= digit_req_d;
      selector_q   <= selector_d;
      segments_q   <= segments_d;
      frame_tick_q <= frame_tick_d;
      fetch_miss_q <= fetch_miss_d;
    end
  end

  assign digit_req  = digit_req_q;
  assign digit_idx  = idx_q;
  assign selector   = selector_q;
  assign segments   = segments_q;
  assign frame_tick = frame_tick_q;
  assign fetch_miss = fetch_miss_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl with a 40-clock slot, 8 blank clocks
// and 3-bit brightness; expected outputs come from slot/digit position.
module tb_display_scan_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [2:0] brightness = 3'd0;
  logic       digit_req;
  logic [1:0] digit_idx;
  logic       digit_ack = 1'b0;
  logic [7:0] digit_data;
  logic [3:0] selector;
  logic [7:0] segments;
  logic       frame_tick;
  logic       fetch_miss;
`ifdef SCAN_BLINK_EN
  logic [3:0] blink_mask = 4'b0100;
`endif

  int   n_checks = 0;
  int   n_err = 0;
  int   gk = 0;
  int   ack_mode = 1;
  int   reqcnt = 0;
  bit   use_tbl = 1'b0;
  int   cur_lit = 32;
  int   req_len = 1;
  bit   miss_mode = 1'b0;
  bit   blink_chk = 1'b0;
  logic [7:0]  pat_tbl [4] = '{8'h06, 8'h5B, 8'h4F, 8'h66};
  logic [16:0] act;

  always #5 clk = ~clk;

  display_scan_ctrl #(
    .DIGITS      (4),
    .SLOT_CYCLES (40),
    .BLANK_CYCLES(8),
    .BRIGHT_W    (3)
`ifdef SCAN_BLINK_EN
    ,
    .BLINK_FRAMES(2)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .brightness(brightness),
    .digit_req (digit_req),
    .digit_idx (digit_idx),
    .digit_ack (digit_ack),
    .digit_data(digit_data),
`ifdef SCAN_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .selector  (selector),
    .segments  (segments),
    .frame_tick(frame_tick),
    .fetch_miss(fetch_miss)
  );

  assign digit_data = use_tbl ? pat_tbl[digit_idx] : 8'h3F;
  assign act = {digit_req, digit_idx, selector, segments, frame_tick, fetch_miss};

  // ack_mode: 0 never, 1 tied high, N>1 ack on the Nth cycle of a request
  always @(posedge clk) begin
    #1;
    if (ack_mode == 0) begin
      digit_ack = 1'b0;
      reqcnt = 0;
    end else if (ack_mode == 1) begin
      digit_ack = 1'b1;
    end else if (digit_req) begin
      reqcnt++;
      digit_ack = (reqcnt == ack_mode);
    end else begin
      reqcnt = 0;
      digit_ack = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [16:0] actual, input logic [16:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_err++;
      $display("FAIL %s act=%h exp=%h", tag, actual, expected);
    end
  endtask

  // {req, idx, selector, segments, frame_tick, fetch_miss} for frame cycle g
  function automatic logic [16:0] exp_out(input int g);
    int k = g % 40;
    int dig = (g / 40) % 4;
    int frame = g / 160;
    logic [7:0] pat, seg;
    logic [3:0] sel;
    bit lit;
    pat = miss_mode ? 8'h00 : (use_tbl ? pat_tbl[dig] : 8'h3F);
    lit = (k >= 8) && (k < 8 + cur_lit);
    sel = lit ? (4'b0001 << dig) : 4'b0000;
    seg = lit ? pat : 8'h00;
    if (blink_chk && dig == 2 && (frame == 2 || frame == 3)) seg = 8'h00;
    return {(k < req_len), 2'(dig), sel, seg, (dig == 3 && k == 39), (miss_mode && k == 8)};
  endfunction

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("%s@%0d", tag, gk), act, exp_out(gk));
      gk++;
    end
  endtask

  task automatic restart(input int mode, input bit tbl, input logic [2:0] b, input int lit,
                         input int rl, input bit miss, input bit blink);
    reset = 1'b1;
    enable = 1'b0;
    ack_mode = mode;
    use_tbl = tbl;
    cur_lit = lit;
    req_len = rl;
    miss_mode = miss;
    blink_chk = blink;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset", act, 17'd0);
    reset = 1'b0;
    enable = 1'b1;
    brightness = b;
    gk = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    restart(1, 1'b0, 3'd7, 32, 1, 1'b0, 1'b0);
    run("full", 240);

    restart(1, 1'b1, 3'd1, 8, 1, 1'b0, 1'b0);
    run("br1", 21);
    brightness = 3'd3;
    run("br1", 19);
    cur_lit = 16;
    run("br3", 40);

    restart(3, 1'b0, 3'd7, 32, 3, 1'b0, 1'b0);
    run("ackdly", 80);

    restart(0, 1'b0, 3'd7, 32, 8, 1'b1, 1'b0);
    run("noack", 160);

    restart(1, 1'b0, 3'd7, 32, 1, 1'b0, 1'b0);
    run("prerst", 101);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid", act, 17'd0);
    reset = 1'b0;
    gk = 0;
    run("postrst", 50);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("en_off@%0d", i), act, 17'd0);
    end
    enable = 1'b1;
    gk = 0;
    run("reen", 40);

`ifdef SCAN_BLINK_EN
    restart(1, 1'b0, 3'd7, 32, 1, 1'b0, 1'b1);
    run("blink", 960);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
